// File: rtl/fwft_fifo_rr_sched_v1_0.sv
// rtl/fwft_fifo_rr_sched_v1_0.sv - round-robin scheduler draining FWFT FIFOs into one valid/ready stream
// Packet mode holds the grant until a last word; burst mode releases after MAX_BURST words or on empty.
module fwft_fifo_rr_sched_v1_0 #(
  parameter int N_CHAN    = 4,
  parameter int WIDTH     = 9,
  parameter int PKT_MODE  = 1,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CHAN-1:0]         chan_en,
  input  logic [N_CHAN*WIDTH-1:0]   fifo_rdata,
  input  logic [N_CHAN-1:0]         fifo_rdata_vld,
  output logic [N_CHAN-1:0]         fifo_rden,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(N_CHAN)-1:0] out_chan,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic                      busy
);
  localparam int CW = $clog2(N_CHAN);
  localparam logic [15:0] BURST_LIM = 16'(MAX_BURST);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     g, g_nxt, rr_ptr, rr_nxt, winner, idx;
  logic [CW:0]       sum;
  logic [15:0]       burst_cnt, burst_nxt;
  logic [N_CHAN-1:0] req;
  logic              found, pop;
  logic [WIDTH-1:0]  g_data;

  assign req  = chan_en & fifo_rdata_vld;
  assign busy = (state == GRANT);

  always_comb begin
    g_data = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (g == CW'(i)) g_data = fifo_rdata[i*WIDTH +: WIDTH];
    end
  end

  // Candidates rr_ptr+1 .. rr_ptr+N_CHAN; the previous winner is considered last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int i = 1; i <= N_CHAN; i++) begin
      sum = {1'b0, rr_ptr} + (CW+1)'(i);
      if (sum >= (CW+1)'(N_CHAN)) sum = sum - (CW+1)'(N_CHAN);
      idx = sum[CW-1:0];
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    rr_nxt    = rr_ptr;
    burst_nxt = burst_cnt;
    pop       = 1'b0;
    fifo_rden = '0;
    case (state)
      IDLE: begin
        if (found) begin
          g_nxt     = winner;
          rr_nxt    = winner;
          burst_nxt = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        pop          = fifo_rdata_vld[g] & (~out_vld | out_rdy);
        fifo_rden[g] = pop;
        if (pop) begin
          burst_nxt = burst_cnt + 16'd1;
          if (PKT_MODE != 0) begin
            if (g_data[WIDTH-1]) state_nxt = IDLE;
          end else if (burst_nxt == BURST_LIM) begin
            state_nxt = IDLE;
          end
        end else if (PKT_MODE == 0 && !fifo_rdata_vld[g]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      g         <= '0;
      rr_ptr    <= CW'(N_CHAN-1);
      burst_cnt <= '0;
      out_data  <= '0;
      out_chan  <= '0;
      out_vld   <= 1'b0;
    end else begin
      state     <= state_nxt;
      g         <= g_nxt;
      rr_ptr    <= rr_nxt;
      burst_cnt <= burst_nxt;
      // The output register drains in IDLE too, so a held word is never repeated.
      if (pop) begin
        out_data <= g_data;
        out_chan <= g;
        out_vld  <= 1'b1;
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fwft_fifo_rr_sched_v1_0.sv
// tb/tb_fwft_fifo_rr_sched_v1_0.sv - scoreboard bench for the round-robin FWFT scheduler
// A packet-mode and a burst-mode instance share one modelled set of FIFOs; mode_bst selects which is live.
module tb_fwft_fifo_rr_sched_v1_0;
  localparam int NC = 4;
  localparam int W  = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, out_rdy, mode_bst;
  logic [NC-1:0]   chan_en, vld, gate, vld_p, vld_b, rden_p, rden_b, rden;
  logic [NC*W-1:0] rdata;
  logic [W-1:0]    data_p, data_b, odata;
  logic [1:0]      ch_p, ch_b, ochan;
  logic            ov_p, ov_b, ovld, busy_p, busy_b, busy;

  assign vld_p = mode_bst ? '0 : vld;
  assign vld_b = mode_bst ? vld : '0;
  assign rden  = mode_bst ? rden_b : rden_p;
  assign odata = mode_bst ? data_b : data_p;
  assign ochan = mode_bst ? ch_b : ch_p;
  assign ovld  = mode_bst ? ov_b : ov_p;
  assign busy  = mode_bst ? busy_b : busy_p;

  fwft_fifo_rr_sched_v1_0 #(.N_CHAN(NC), .WIDTH(W), .PKT_MODE(1), .MAX_BURST(16)) u_pkt (
    .clk(clk), .rst_n(rst_n), .chan_en(chan_en), .fifo_rdata(rdata), .fifo_rdata_vld(vld_p),
    .fifo_rden(rden_p), .out_data(data_p), .out_chan(ch_p), .out_vld(ov_p), .out_rdy(out_rdy),
    .busy(busy_p));

  fwft_fifo_rr_sched_v1_0 #(.N_CHAN(NC), .WIDTH(W), .PKT_MODE(0), .MAX_BURST(2)) u_bst (
    .clk(clk), .rst_n(rst_n), .chan_en(chan_en), .fifo_rdata(rdata), .fifo_rdata_vld(vld_b),
    .fifo_rden(rden_b), .out_data(data_b), .out_chan(ch_b), .out_vld(ov_b), .out_rdy(out_rdy),
    .busy(busy_b));

  logic [W-1:0]  fq[NC][$];
  logic [W-1:0]  eq[NC][$];
  int            ord_q[$];
  int            n_chk = 0, n_pass = 0, cyc = 0, words_left = 0;
  int            pop_cnt[NC];
  int            first_x, last_x, c0;
  logic [NC-1:0] pops_rec;
  logic          rand_mode, toggle_rdy, grant_pend, in_pkt, prev_stall;
  logic [1:0]    rr_m, exp_g, cur_chan;
  logic [W-1:0]  prev_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < NC; i++) begin
      vld[i] = gate[i] && (fq[i].size() != 0);
      rdata[i*W +: W] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic push_pkt(input int c, input int len);
    logic [W-1:0] w;
    for (int k = 0; k < len; k++) begin
      w = {(k == len-1), 8'($urandom)};
      fq[c].push_back(w);
      eq[c].push_back(w);
    end
    drive();
  endtask

  function automatic int pending(input logic [NC-1:0] m);
    int s = ovld ? 1 : 0;
    for (int i = 0; i < NC; i++) if (m[i]) s += eq[i].size();
    return s;
  endfunction

  task automatic monitor();
    logic [NC-1:0] req;
    logic ok;
    int idx;
    pops_rec = '0;
    if (!rst_n) return;
    pops_rec = rden & vld;
    ok = $onehot0(rden) && ((rden & ~vld) == 0) && (busy || rden == 0) && !(ovld && !out_rdy && rden != 0);
    check("rden_legal", ok, 1);
    if (prev_stall) begin
      check("stall_vld", ovld, 1);
      check("stall_data", odata, prev_data);
    end
    prev_stall = ovld && !out_rdy;
    prev_data  = odata;
    for (int i = 0; i < NC; i++) if (pops_rec[i]) pop_cnt[i]++;
    // Reference round-robin: the first pop after an IDLE decision must come from the modelled winner.
    if (grant_pend && rden != 0) begin
      check("rr_grant", rden, 4'b1 << exp_g);
      grant_pend = 1'b0;
    end
    req = chan_en & vld;
    if (!busy && req != 0) begin
      for (int k = 1; k <= NC; k++) begin
        idx = (int'(rr_m) + k) % NC;
        if (req[idx]) begin
          exp_g = 2'(idx);
          break;
        end
      end
      rr_m = exp_g;
      grant_pend = 1'b1;
    end
    if (ovld && out_rdy) begin
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
      if (eq[ochan].size() == 0) check("sb_unexpected_word", 0, 1);
      else check("sb_data", odata, eq[ochan].pop_front());
      if (ord_q.size() != 0) check("order", ochan, ord_q.pop_front());
      if (!mode_bst) begin
        if (in_pkt) check("no_interleave", ochan, cur_chan);
        cur_chan = ochan;
        in_pkt = !odata[W-1];
      end
    end
  endtask

  task automatic apply();
    int len;
    for (int i = 0; i < NC; i++) if (pops_rec[i]) void'(fq[i].pop_front());
    pops_rec = '0;
    if (toggle_rdy) out_rdy = ~out_rdy;
    if (rand_mode) begin
      for (int i = 0; i < NC; i++) gate[i] = ($urandom_range(0, 4) != 0);
      out_rdy = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NC; i++) begin
        if (fq[i].size() < 3 && words_left > 0) begin
          len = $urandom_range(1, 4);
          if (len > words_left) len = words_left;
          push_pkt(i, len);
          words_left -= len;
        end
      end
    end
    drive();
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    apply();
  endtask

  task automatic drain(input string tag, input logic [NC-1:0] m, input int max);
    int k = 0;
    while (pending(m) != 0 && k < max) begin
      step();
      k++;
    end
    check(tag, pending(m), 0);
  endtask

  task automatic do_reset(input logic bst);
    rst_n = 1'b0;
    mode_bst = bst;
    for (int i = 0; i < NC; i++) begin
      fq[i].delete();
      eq[i].delete();
      pop_cnt[i] = 0;
    end
    ord_q.delete();
    chan_en = '1; gate = '1; out_rdy = 1'b1;
    rand_mode = 1'b0; toggle_rdy = 1'b0;
    rr_m = 2'd3; grant_pend = 1'b0; in_pkt = 1'b0; prev_stall = 1'b0; pops_rec = '0;
    first_x = -1; last_x = -1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_vld", ovld, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", odata, 0);
    check("rst_out_chan", ochan, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset mid-transfer, then lowest requester wins.
    do_reset(1'b0);
    push_pkt(2, 4);
    repeat (3) step();
    check("t1_pre_busy", busy, 1);
    check("t1_pre_vld", ovld, 1);
    rst_n = 1'b0;
    #1;
    check("t1_async_vld", ovld, 0);
    check("t1_async_rden", rden, 0);
    check("t1_async_busy", busy, 0);
    do_reset(1'b0);
    push_pkt(2, 1);
    push_pkt(1, 1);
    ord_q = '{1, 2};
    drain("t1_drain", '1, 50);

    // Four 3-word packets, fixed order and timing.
    do_reset(1'b0);
    for (int c = 0; c < NC; c++) begin
      push_pkt(c, 3);
      repeat (3) ord_q.push_back(c);
    end
    c0 = cyc;
    drain("t2_drain", '1, 100);
    check("t2_first_latency", first_x - c0, 2);
    check("t2_last_xfer", last_x - c0, 16);

    // Alternating backpressure.
    do_reset(1'b0);
    push_pkt(2, 4);
    toggle_rdy = 1'b1;
    drain("t3_drain", '1, 100);
    toggle_rdy = 1'b0;

    // Burst mode, MAX_BURST=2.
    do_reset(1'b1);
    push_pkt(1, 5);
    push_pkt(2, 1);
    ord_q = '{1, 1, 2, 1, 1, 1};
    drain("t4_drain", '1, 100);

    // Packet stall on chan 0 while chan 3 waits, then chan 3 disabled.
    do_reset(1'b0);
    push_pkt(0, 4);
    push_pkt(3, 2);
    ord_q = '{0, 0, 0, 0, 1};
    repeat (3) step();
    gate[0] = 1'b0;
    drive();
    repeat (10) step();
    check("t5_hold_busy", busy, 1);
    check("t5_chan0_pops", pop_cnt[0], 2);
    check("t5_chan3_pops", pop_cnt[3], 0);
    chan_en[3] = 1'b0;
    gate[0] = 1'b1;
    drive();
    push_pkt(1, 1);
    drain("t5_drain", 4'b0111, 100);
    repeat (10) step();
    check("t5_chan3_never", pop_cnt[3], 0);
    check("t5_chan3_left", eq[3].size(), 2);

    // Random traffic, 10k words.
    do_reset(1'b0);
    words_left = 10000;
    rand_mode = 1'b1;
    for (int k = 0; k < 60000 && (words_left > 0 || pending('1) != 0); k++) step();
    rand_mode = 1'b0;
    check("t6_words_left", words_left, 0);
    check("t6_drain", pending('1), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
